// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: shift-add-3 (double dabble), one input bit per clock,
// with a start/busy/done handshake and sign/overflow reporting.
module bcd_seq_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      numero,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned BcdW = 4 * DIGITS;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic            sticky_q, sticky_d;
  logic            neg_w_q, neg_w_d;
  logic [BcdW-1:0] digits_q, digits_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_in;
  logic [BcdW-1:0]  bcd_adj;
  logic [BcdW-1:0]  bcd_shift;
  logic             shift_out;

  // Two's-complement magnitude; the most-negative value wraps to 2^(WIDTH-1) as unsigned.
  assign mag_in = numero[WIDTH-1] ? ((~numero) + WIDTH'(1)) : numero;

  // All digits are adjusted in parallel from the pre-edge register contents.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  assign bcd_shift = {bcd_adj[BcdW-2:0], mag_q[WIDTH-1]};
  assign shift_out = bcd_adj[BcdW-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    neg_w_d  = neg_w_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_w_d  = numero[WIDTH-1];
          mag_d    = mag_in;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CntW'(WIDTH - 1);
          state_d  = StShift;
        end
      end
      StShift: begin
        bcd_d    = bcd_shift;
        mag_d    = {mag_q[WIDTH-2:0], 1'b0};
        sticky_d = sticky_q | shift_out;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          digits_d = bcd_shift;
          neg_d    = neg_w_q;
          ovf_d    = sticky_q | shift_out;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mag_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      neg_w_q  <= 1'b0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      neg_w_q  <= neg_w_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign digits   = digits_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl at WIDTH=32, DIGITS=4 with hand-computed expectations.
module tb_bcd_seq_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] numero;
  logic        busy;
  logic        done;
  logic        neg;
  logic        overflow;
  logic [15:0] digits;

  int compared   = 0;
  int mismatched = 0;

  bcd_seq_ctrl #(
    .WIDTH  (32),
    .DIGITS (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .numero   (numero),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .overflow (overflow),
    .digits   (digits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a conversion of v and returns in the DONE cycle (or after a timeout).
  // With inj set, start is pulsed with a different value at sample inj and during DONE.
  task automatic run(input logic [31:0] v, input int inj, output int lat, output int bsy);
    numero = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    numero = ~v;
    lat = 0;
    bsy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bsy++;
      if (inj != 0 && lat == inj) begin
        start  = 1'b1;
        numero = 32'd999;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    if (inj != 0) begin
      start  = 1'b1;
      numero = 32'd999;
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [15:0] exp_dig,
                         input logic exp_neg, input logic exp_ovf);
    int lat, bsy;
    run(v, 0, lat, bsy);
    check({tag, "_latency"}, lat, 32);
    check({tag, "_digits"}, {16'h0, digits}, {16'h0, exp_dig});
    check({tag, "_neg"}, {31'h0, neg}, {31'h0, exp_neg});
    check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, exp_ovf});
    step();
    check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int lat, bsy, dones;
    reset  = 1'b1;
    start  = 1'b0;
    numero = '0;
    step();
    step();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_digits", {16'h0, digits}, 32'h0);
    check("rst_neg_ovf", {30'h0, neg, overflow}, 32'h0);
    reset = 1'b0;
    step();

    // Test 1 with explicit busy accounting.
    run(32'd47, 0, lat, bsy);
    check("t1_latency", lat, 32);
    check("t1_busy_cycles", bsy, 32);
    check("t1_busy_in_done", {31'h0, busy}, 32'h0);
    check("t1_digits", {16'h0, digits}, 32'h0047);
    check("t1_neg_ovf", {30'h0, neg, overflow}, 32'h0);
    step();
    check("t1_done_pulse", {31'h0, done}, 32'h0);

    convert("neg47", 32'hFFFF_FFD1, 16'h0047, 1'b1, 1'b0);
    convert("zero", 32'd0, 16'h0000, 1'b0, 1'b0);
    convert("b9999", 32'd9999, 16'h9999, 1'b0, 1'b0);
    convert("b10000", 32'd10000, 16'h0000, 1'b0, 1'b1);
    convert("b12345", 32'd12345, 16'h2345, 1'b0, 1'b1);
    convert("minneg", 32'h8000_0000, 16'h3648, 1'b1, 1'b1);

    // Start pulses mid-conversion and in DONE are ignored.
    run(32'd47, 5, lat, bsy);
    check("t5_latency", lat, 32);
    check("t5_digits", {16'h0, digits}, 32'h0047);
    check("t5_neg_ovf", {30'h0, neg, overflow}, 32'h0);
    step();
    start = 1'b0;
    check("t5_idle_after_done", {30'h0, busy, done}, 32'h0);
    step();
    check("t5_no_restart", {30'h0, busy, done}, 32'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    check("t5_no_extra_done", dones, 0);
    check("t5_digits_held", {16'h0, digits}, 32'h0047);

    // Reset 10 cycles into a conversion.
    numero = 32'd9999;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("t6_busy_before_rst", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_busy_done", {30'h0, busy, done}, 32'h0);
    check("t6_rst_digits", {16'h0, digits}, 32'h0);
    check("t6_rst_neg_ovf", {30'h0, neg, overflow}, 32'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      step();
    end
    check("t6_no_done_after_abort", dones, 0);
    convert("t6_fresh123", 32'd123, 16'h0123, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
Name: bcd_seq_ctrl

Overview:
Sequential, handshaked binary-to-BCD conversion controller for the display path. It captures a signed WIDTH-bit value and runs the shift-add-3 (double dabble) algorithm one bit per clock, so a single small datapath replaces the fully unrolled combinational converter. It reports DIGITS decimal digits, a sign flag and an overflow flag, and its start/busy/done handshake lets the display logic schedule conversions.

Parameters:
WIDTH, 32, bit width of the two's-complement input.
DIGITS, 4, number of BCD digits produced; the legal range is 1..10.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion; sampled only in IDLE.
numero  input  WIDTH  signed value; sampled on the edge that accepts start.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
neg  output  1  sign of the last converted value.
overflow  output  1  high when |value| >= 10^DIGITS for the last conversion.
digits  output  4*DIGITS  BCD result; digit k is in bits [4k+3:4k], and k=0 is the units digit.

Behaviour:
- Reset, synchronous and active-high, at any time including mid-conversion:
  - state goes to IDLE;
  - busy, done, neg, overflow and digits all become 0;
  - the counter and working registers clear;
  - an aborted conversion never produces done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1 (edge E0):
    - latch neg_w = numero[WIDTH-1];
    - latch mag = neg_w ? (~numero + 1) : numero, as a WIDTH-bit unsigned value;
    - clear the BCD working register and the sticky overflow;
    - load the bit counter with WIDTH-1;
    - go to SHIFT.
- SHIFT, one input bit per edge, MSB first, for edges E1..E_WIDTH. Each edge does the following:
  - adds 3 to every working digit that is >= 5, with all digits evaluated in parallel from the pre-edge values;
  - shifts the adjusted BCD register left by 1, with bit 0 taking the current MSB of mag;
  - shifts mag left by 1;
  - ORs the bit shifted out of the top digit into the sticky overflow;
  - decrements the counter.
  - On the edge where the counter is 0:
    - register the final digits into digits;
    - register neg_w into neg and the sticky flag into overflow;
    - go to DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly this cycle, busy=0;
  - next edge goes to IDLE unconditionally;
  - start is ignored in DONE.
- Latency: done is high in the cycle following edge E_WIDTH, which is 32 cycles after the accepting edge at default WIDTH. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored. numero changes after E0 do not affect the result.
- Outputs digits, neg and overflow hold their values between conversions. They change only at the final SHIFT edge or on reset.
- Overflow case: digits = |value| mod 10^DIGITS and overflow=1.
- Most-negative input 2^(WIDTH-1) converts as an unsigned magnitude with neg=1, with no special case.
- Zero input: digits=0, neg=0, overflow=0.

Test Plan:
1. Reset, then start with numero=47 (0x0000002F) -> done exactly 32 cycles after the accepting edge; digits=0x0047, neg=0, overflow=0; busy high for 32 cycles.
2. numero=0xFFFFFFD1 (-47) -> digits=0x0047, neg=1, overflow=0. Then numero=0 -> digits=0x0000, neg=0, overflow=0.
3. Boundaries at DIGITS=4:
   - 9999 -> digits=0x9999, overflow=0;
   - 10000 -> digits=0x0000, overflow=1;
   - 12345 -> digits=0x2345, overflow=1.
4. numero=0x80000000 -> digits=0x3648, neg=1, overflow=1.
5. Pulse start again 5 cycles into a conversion, and also during the DONE cycle, with a different numero -> both ignored; the first result is unchanged; a single done pulse; state returns to IDLE.
6. Assert reset at cycle 10 of a conversion -> next cycle all outputs are 0 and state is IDLE; no done pulse. A fresh start with 123 then yields digits=0x0123.
